// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter and its register file.
// Requester indices, R0 index and default datapath widths.
package regfile_write_arbiter_pkg;

   typedef enum logic [1:0] {
      REQ_ALU = 2'd0,
      REQ_MEM = 2'd1,
      REQ_MD  = 2'd2
   } req_idx_e;

   localparam int unsigned NUM_REQ   = 3;
   localparam int unsigned R0_IDX    = 0;
   localparam int unsigned RF_DATA_W = 16;
   localparam int unsigned RF_ADDR_W = 4;

   // Successor in the round-robin ring; the unused encoding folds onto ALU.
   function automatic req_idx_e next_idx(input req_idx_e i);
      case (i)
         REQ_ALU: return REQ_MEM;
         REQ_MEM: return REQ_MD;
         default: return REQ_ALU;
      endcase
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter3.sv
// Three-way round-robin grant generator: the requester after `last` has top priority.
// Produces a one-hot grant, or no grant when disabled or nobody is requesting.
module rr_arbiter3
   import regfile_write_arbiter_pkg::*;
(
   input  logic               en,
   input  logic [NUM_REQ-1:0] valid,
   input  req_idx_e           last,
   output logic [NUM_REQ-1:0] grant
);

   req_idx_e idx;

   always_comb begin
      grant = '0;
      idx   = next_idx(last);
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (en && (grant == '0) && valid[idx]) begin
            grant[idx] = 1'b1;
         end
         idx = next_idx(idx);
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among ALU, load unit and mul/div, one write per cycle.
// Tracks R0 locally because the register file rewrites R0 on every strobe.
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int unsigned         DATA_W   = RF_DATA_W,
   parameter int unsigned         ADDR_W   = RF_ADDR_W,
   parameter logic [DATA_W-1:0]   R0_RESET = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hold,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              md_valid,
   output logic              md_ready,
   input  logic [ADDR_W-1:0] md_rd,
   input  logic [DATA_W-1:0] md_data,
   input  logic              md_r0_en,
   input  logic [DATA_W-1:0] md_r0_data,
   output logic              registerWrite,
   output logic [ADDR_W-1:0] regWriteLocal,
   output logic [DATA_W-1:0] dataWrite,
   output logic [DATA_W-1:0] r0Write,
   output logic [DATA_W-1:0] r0_shadow,
   output logic              proto_err
);

   logic [NUM_REQ-1:0] valid_vec;
   logic [NUM_REQ-1:0] grant;
   logic               accept;

   req_idx_e           last_q, last_d;
   logic               reg_write_q, reg_write_d;
   logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]  wr_data_q, wr_data_d;
   logic [DATA_W-1:0]  r0_write_q, r0_write_d;
   logic [DATA_W-1:0]  r0_shadow_q, r0_shadow_d;
   logic               proto_err_q, proto_err_d;

   logic [ADDR_W-1:0]  sel_rd;
   logic [DATA_W-1:0]  sel_data;
   logic               sel_r0_en;
   logic [DATA_W-1:0]  r0_new;

   always_comb begin
      valid_vec          = '0;
      valid_vec[REQ_ALU] = alu_valid;
      valid_vec[REQ_MEM] = mem_valid;
      valid_vec[REQ_MD]  = md_valid;
   end

   rr_arbiter3 u_rr (
      .en    (!hold && !reset),
      .valid (valid_vec),
      .last  (last_q),
      .grant (grant)
   );

   assign alu_ready = grant[REQ_ALU];
   assign mem_ready = grant[REQ_MEM];
   assign md_ready  = grant[REQ_MD];
   assign accept    = |grant;

   always_comb begin
      sel_rd    = alu_rd;
      sel_data  = alu_data;
      sel_r0_en = 1'b0;
      last_d    = last_q;
      if (grant[REQ_ALU]) begin
         last_d = REQ_ALU;
      end else if (grant[REQ_MEM]) begin
         sel_rd   = mem_rd;
         sel_data = mem_data;
         last_d   = REQ_MEM;
      end else if (grant[REQ_MD]) begin
         sel_rd    = md_rd;
         sel_data  = md_data;
         sel_r0_en = md_r0_en;
         last_d    = REQ_MD;
      end
   end

   // The dedicated R0 port wins over an addressed write to R0; otherwise R0 is re-driven unchanged.
   always_comb begin
      if (sel_r0_en)
         r0_new = md_r0_data;
      else if (sel_rd == ADDR_W'(R0_IDX))
         r0_new = sel_data;
      else
         r0_new = r0_shadow_q;
   end

   always_comb begin
      reg_write_d = accept;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      r0_write_d  = r0_write_q;
      r0_shadow_d = r0_shadow_q;
      proto_err_d = proto_err_q;
      if (accept) begin
         wr_addr_d   = sel_rd;
         wr_data_d   = sel_data;
         r0_write_d  = r0_new;
         r0_shadow_d = r0_new;
         if (grant[REQ_MD] && md_r0_en && (md_rd == ADDR_W'(R0_IDX)))
            proto_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q      <= REQ_MD;
         reg_write_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         r0_write_q  <= '0;
         r0_shadow_q <= R0_RESET;
         proto_err_q <= 1'b0;
      end else begin
         last_q      <= last_d;
         reg_write_q <= reg_write_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         r0_write_q  <= r0_write_d;
         r0_shadow_q <= r0_shadow_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign registerWrite = reg_write_q;
   assign regWriteLocal = wr_addr_q;
   assign dataWrite     = wr_data_q;
   assign r0Write       = r0_write_q;
   assign r0_shadow     = r0_shadow_q;
   assign proto_err     = proto_err_q;

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 16×16-bit register file among three writeback requesters: ALU, memory/load unit and multiply/divide unit. The multiply/divide unit may also write R0 through the register file's dedicated R0 port. The block arbitrates round-robin and issues one registered write per cycle. It keeps a shadow copy of R0, because the register file rewrites R0 on every write strobe and its own R0 read-back lags by one cycle. It sits between the writeback stage and the register file's write inputs.

## Interface
- DATA_W, 16, register data width
- ADDR_W, 4, register index width
- R0_RESET, 16'h0000, reset value of the R0 shadow; must match the register file's R0 reset value

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- hold  in  1  when high, no grants are issued
- alu_valid / alu_ready  in / out  1 / 1  ALU request handshake
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU write data
- mem_valid / mem_ready  in / out  1 / 1  load-unit request handshake
- mem_rd  in  ADDR_W  load-unit destination register
- mem_data  in  DATA_W  load-unit write data
- md_valid / md_ready  in / out  1 / 1  mul/div request handshake
- md_rd  in  ADDR_W  mul/div destination register
- md_data  in  DATA_W  mul/div write data
- md_r0_en  in  1  mul/div also writes R0 (remainder / upper half)
- md_r0_data  in  DATA_W  R0 write data
- registerWrite  out  1  register file write strobe
- regWriteLocal  out  ADDR_W  register file write index
- dataWrite  out  DATA_W  register file write data
- r0Write  out  DATA_W  register file R0 write data
- r0_shadow  out  DATA_W  current architectural R0 value
- proto_err  out  1  sticky protocol-error flag

## Operation
- **Requester indices:** 0 = ALU, 1 = MEM, 2 = MD.
- **Round-robin pointer** `last` (2 bits) holds the last granted index.
- **Priority order** starts at (last+1) mod 3, scanning upward with wrap.
- **Grant:** at most one ready is high per cycle, combinationally. It goes to the first valid requester in priority order, and only while hold=0 and reset=0.
- **Acceptance** happens when valid & ready. A requester must hold its valid and payload stable until accepted.
- **Pointer update:** on acceptance, `last` ← the granted index. With no acceptance, `last` holds.
- **Issue register**, loaded on acceptance:
  - registerWrite←1, regWriteLocal←rd, dataWrite←data.
  - With no acceptance, registerWrite←0 and the other outputs hold.
- **R0 resolution for the accepted request** (new value N):
  - MD with md_r0_en=1: N = md_r0_data.
  - Otherwise, rd==0: N = data.
  - Otherwise: N = r0_shadow.
  - r0Write←N and r0_shadow←N, on the same edge as the issue register.
- **Shadow invariant:** r0_shadow always equals the R0 value the register file holds once the issued write lands.
- **Protocol error:** proto_err is set when MD is accepted with md_r0_en=1 and md_rd==0.
  - The write still issues: dataWrite=md_data, r0Write=md_r0_data. R0 ends up as md_r0_data.
  - proto_err stays set until reset.

## Timing
- **Latency:** a request accepted in cycle N appears on the write outputs during cycle N+1. The register file commits it at the end of N+1.
- **Throughput:** one write per cycle, sustained.
- **Fairness:** under continuous requests from all three, grants cycle 0,1,2,0,… With only a subset requesting, no requester waits more than 2 grants.
- **Reset values:** registerWrite=0, regWriteLocal=0, dataWrite=0, r0Write=0, r0_shadow=R0_RESET, proto_err=0, last=2 (ALU highest priority first), all readies 0.
- **Reset mid-operation:** an accepted-but-unissued write is dropped. Requesters must reissue after reset.
- **hold:** readies go low in the same cycle hold=1. A write issued in the previous cycle still appears. `last` is frozen.
- **Simultaneous valids:** resolved purely by the pointer. Payload contents never affect arbitration.

## Structure
- A shared package holds:
  - requester index constants (REQ_ALU=0, REQ_MEM=1, REQ_MD=2) and NUM_REQ=3;
  - the R0 index constant (0);
  - DATA_W/ADDR_W defaults, shared with the register file.
- One natural sub-module: rr_arbiter3, a 3-way round-robin grant generator (valid vector + pointer in, one-hot grant out).
- Payload muxing, R0 resolution and the issue register stay in the top.

## Test plan
- **Single write:** after reset, alu_valid=1, alu_rd=5, alu_data=16'h1234.
  - alu_ready=1 the same cycle.
  - Next cycle: registerWrite=1, regWriteLocal=5, dataWrite=16'h1234, r0Write=16'h0000.
- **All three valid for 6 cycles:** grant order ALU, MEM, MD, ALU, MEM, MD. registerWrite is high for 6 consecutive cycles, starting 1 cycle later.
- **MD with R0:** md_rd=3, md_data=16'hAAAA, md_r0_en=1, md_r0_data=16'h0007.
  - regWriteLocal=3, r0Write=16'h0007, r0_shadow=16'h0007.
  - A following ALU write to R4 carries r0Write=16'h0007.
- **ALU write to R0:** alu_rd=0, alu_data=16'h00FF → dataWrite=r0Write=16'h00FF, r0_shadow=16'h00FF.
- **Protocol error:** MD with md_rd=0, md_data=16'h1111, md_r0_en=1, md_r0_data=16'h2222 → r0Write=16'h2222 and proto_err=1, staying high until reset.
- **hold and reset:**
  - With hold=1 and all valids high: all readies 0, registerWrite=0 from the next cycle.
  - Reset asserted the cycle after an acceptance: registerWrite=0 and r0_shadow=R0_RESET on the next cycle.
